usb_ls_rx: RTL and testbench

//  Low-speed (1.5 Mb/s) USB receive front-end for the slowworm PMOD. It runs on the 12 MHz board clock at 8x oversampling.
//  - Input path: raw D+/D- pins -> 2-flop synchronizer -> line state -> DPLL bit sampling -> NRZI decode -> bit unstuff -> SYNC/EOP framing.
//  - Output: received bytes with strobes to the downstream packet/PID decoder. Debug taps go to the top-level LEDs/ACTIVITY.

---
 rtl/pkg_usb.sv | 22 ++
 rtl/usb_ls_dpll.sv | 67 ++++++
 rtl/usb_ls_rx.sv | 207 ++++++++++++++++++++
 tb/tb_usb_ls_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_usb.sv
// rtl/pkg_usb.sv - shared types and constants for the low-speed USB receiver
package pkg_usb;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERR
    } rx_state_t;

    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    localparam logic [2:0] STUFF_RUN      = 3'd6;

endpackage

// File: rtl/usb_ls_dpll.sv
// rtl/usb_ls_dpll.sv - pad synchronizer, line state register and bit-centre sampling DPLL
module usb_ls_dpll
    import pkg_usb::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dp,
    input  logic        i_dm,
    output line_state_t o_line_state,
    output logic        o_sample,
    output line_state_t o_sampled
);

    localparam int              PW      = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0]   PH_HALF = PW'(CLKS_PER_BIT / 2);
    localparam logic [PW-1:0]   PH_LAST = PW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] r_dp_sync;
    logic [SYNC_STAGES-1:0] r_dm_sync;
    line_state_t            r_line_state;
    line_state_t            r_prev_ls;
    line_state_t            r_sampled;
    logic [PW-1:0]          r_phase;
    logic                   r_sample;
    logic [PW-1:0]          w_phase;

    // Any line transition re-centres the phase so the strobe lands mid-bit.
    assign w_phase = (r_line_state != r_prev_ls) ? '0 : r_phase;

    // Synchronize the raw pads (idle J) and register the decoded line state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_sync    <= '0;
            r_dm_sync    <= '1;
            r_line_state <= LS_J;
            r_prev_ls    <= LS_J;
        end else begin
            r_dp_sync    <= {r_dp_sync[SYNC_STAGES-2:0], i_dp};
            r_dm_sync    <= {r_dm_sync[SYNC_STAGES-2:0], i_dm};
            r_line_state <= line_state_t'({r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1]});
            r_prev_ls    <= r_line_state;
        end
    end

    // Free-running phase counter and registered mid-bit sample of the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase   <= '0;
            r_sample  <= 1'b0;
            r_sampled <= LS_J;
        end else begin
            r_phase  <= (w_phase == PH_LAST) ? '0 : w_phase + PW'(1);
            r_sample <= (w_phase == PH_HALF);
            if (w_phase == PH_HALF) begin
                r_sampled <= r_line_state;
            end
        end
    end

    assign o_line_state = r_line_state;
    assign o_sample     = r_sample;
    assign o_sampled    = r_sampled;

endmodule

// File: rtl/usb_ls_rx.sv
// rtl/usb_ls_rx.sv - low-speed USB receive front-end (optional bus-reset detect: USB_RX_BUS_RESET_EN)
module usb_ls_rx
    import pkg_usb::*;
#(
    parameter int CLKS_PER_BIT   = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int BUS_RESET_CLKS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        usb_dp,
    input  logic        usb_dm,
    output line_state_t line_state,
    output logic        rx_active,
    output logic        rx_sop,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_eop,
    output logic        rx_err,
    output logic        bus_reset
);

    localparam int BRW = $clog2(BUS_RESET_CLKS + 1);

    line_state_t w_line_state;
    line_state_t w_sampled;
    logic        w_strobe;
    logic        w_bit;
    logic        w_bus_reset;
    logic [BRW-1:0] w_se0_cnt;

    rx_state_t   r_state, w_state_next;
    line_state_t r_prev_sampled;
    logic [2:0]  r_zeros, w_zeros_next;
    logic [2:0]  r_ones, w_ones_next;
    logic [2:0]  r_bitcnt, w_bitcnt_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [7:0]  r_data, w_data_next;
    logic        r_se0_seen, w_se0_seen_next;
    logic        r_sop, r_valid, r_eop, r_err, r_active;
    logic        w_sop, w_valid, w_eop, w_err;

    usb_ls_dpll #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_dpll (
        .clk          (clk),
        .reset        (reset),
        .i_dp         (usb_dp),
        .i_dm         (usb_dm),
        .o_line_state (w_line_state),
        .o_sample     (w_strobe),
        .o_sampled    (w_sampled)
    );

    // NRZI: no change between samples is a 1.
    assign w_bit = (w_sampled == r_prev_sampled);

`ifdef USB_RX_BUS_RESET_EN
    logic [BRW-1:0] r_se0_cnt;

    // Saturating count of consecutive SE0 cycles on the line.
    always_ff @(posedge clk) begin
        if (reset || (w_line_state != LS_SE0)) begin
            r_se0_cnt <= '0;
        end else if (r_se0_cnt != BRW'(BUS_RESET_CLKS)) begin
            r_se0_cnt <= r_se0_cnt + BRW'(1);
        end
    end

    assign w_se0_cnt = r_se0_cnt;
`else
    assign w_se0_cnt = '0;
`endif

    assign w_bus_reset = (w_se0_cnt >= BRW'(BUS_RESET_CLKS));

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, unstuffing/shift datapath and event pulses, evaluated on each bit strobe.
    always_comb begin
        w_state_next    = r_state;
        w_zeros_next    = r_zeros;
        w_ones_next     = r_ones;
        w_bitcnt_next   = r_bitcnt;
        w_shift_next    = r_shift;
        w_data_next     = r_data;
        w_se0_seen_next = r_se0_seen;
        w_sop           = 1'b0;
        w_valid         = 1'b0;
        w_eop           = 1'b0;
        w_err           = 1'b0;
        if (w_bus_reset) begin
            w_state_next = IDLE;
        end else if (w_strobe) begin
            case (r_state)
                IDLE: begin
                    if (w_sampled == LS_K) begin
                        w_state_next = SYNC;
                        w_zeros_next = 3'd1;
                    end
                end
                SYNC: begin
                    if (w_sampled == LS_SE0 || w_sampled == LS_SE1) begin
                        w_state_next = IDLE;
                    end else if (!w_bit) begin
                        if (r_zeros != 3'd7) w_zeros_next = r_zeros + 3'd1;
                    end else if (r_zeros >= SYNC_MIN_ZEROS) begin
                        w_state_next  = DATA;
                        w_sop         = 1'b1;
                        w_ones_next   = 3'd0;
                        w_bitcnt_next = 3'd0;
                        w_shift_next  = 8'h00;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                DATA: begin
                    if (w_sampled == LS_SE0) begin
                        w_state_next = EOP;
                    end else if (w_sampled == LS_SE1 || (r_ones == STUFF_RUN && w_bit)) begin
                        w_state_next    = ERR;
                        w_err           = 1'b1;
                        w_se0_seen_next = 1'b0;
                    end else if (r_ones == STUFF_RUN) begin
                        w_ones_next = 3'd0;
                    end else begin
                        w_shift_next  = {w_bit, r_shift[7:1]};
                        w_ones_next   = w_bit ? r_ones + 3'd1 : 3'd0;
                        w_bitcnt_next = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_data_next = {w_bit, r_shift[7:1]};
                            w_valid     = 1'b1;
                        end
                    end
                end
                EOP: begin
                    if (w_sampled == LS_J) begin
                        w_state_next = IDLE;
                        w_eop        = (r_bitcnt <= 3'd1);
                        w_err        = (r_bitcnt > 3'd1);
                    end else if (w_sampled != LS_SE0) begin
                        w_state_next    = ERR;
                        w_err           = 1'b1;
                        w_se0_seen_next = 1'b0;
                    end
                end
                ERR: begin
                    if (w_sampled == LS_SE0) begin
                        w_se0_seen_next = 1'b1;
                    end else if (w_sampled == LS_J && r_se0_seen) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath registers and one-cycle output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_sampled <= LS_J;
            r_zeros        <= 3'd0;
            r_ones         <= 3'd0;
            r_bitcnt       <= 3'd0;
            r_shift        <= 8'h00;
            r_data         <= 8'h00;
            r_se0_seen     <= 1'b0;
            r_sop          <= 1'b0;
            r_valid        <= 1'b0;
            r_eop          <= 1'b0;
            r_err          <= 1'b0;
            r_active       <= 1'b0;
        end else begin
            if (w_strobe) r_prev_sampled <= w_sampled;
            r_zeros    <= w_zeros_next;
            r_ones     <= w_ones_next;
            r_bitcnt   <= w_bitcnt_next;
            r_shift    <= w_shift_next;
            r_data     <= w_data_next;
            r_se0_seen <= w_se0_seen_next;
            r_sop      <= w_sop;
            r_valid    <= w_valid;
            r_eop      <= w_eop;
            r_err      <= w_err;
            r_active   <= (w_state_next == DATA) || (w_state_next == EOP);
        end
    end

    assign line_state = w_line_state;
    assign rx_active  = r_active;
    assign rx_sop     = r_sop;
    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign rx_eop     = r_eop;
    assign rx_err     = r_err;
    assign bus_reset  = w_bus_reset;

endmodule

// File: tb/tb_usb_ls_rx.sv
// tb/tb_usb_ls_rx.sv - directed self-checking bench for usb_ls_rx (honours USB_RX_BUS_RESET_EN)
module tb_usb_ls_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       usb_dp;
    logic       usb_dm;
    logic [1:0] line_state;
    logic       rx_active, rx_sop, rx_valid, rx_eop, rx_err, bus_reset;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;

    int n_sop = 0, n_valid = 0, n_eop = 0, n_err = 0, n_br = 0, n_clash = 0, cap_n = 0;
    logic [7:0] cap [0:63];

    int s_sop, s_valid, s_eop, s_err, s_br, s_cap;

    logic [1:0] cur;
    int         ones_run;
    bit         alt;
    bit         alt_phase;

    always #5 clk = ~clk;

    usb_ls_rx dut (
        .clk        (clk),
        .reset      (reset),
        .usb_dp     (usb_dp),
        .usb_dm     (usb_dm),
        .line_state (line_state),
        .rx_active  (rx_active),
        .rx_sop     (rx_sop),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_eop     (rx_eop),
        .rx_err     (rx_err),
        .bus_reset  (bus_reset)
    );

    always @(negedge clk) begin
        if (rx_sop)   n_sop++;
        if (rx_eop)   n_eop++;
        if (rx_err)   n_err++;
        if (bus_reset) n_br++;
        if ((rx_valid && rx_eop) || (rx_err && rx_eop)) n_clash++;
        if (rx_valid) begin
            n_valid++;
            if (cap_n < 64) cap[cap_n] = rx_data;
            cap_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ls, input int n);
        {usb_dp, usb_dm} = ls;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        int p;
        if (!b) cur = (cur == 2'b01) ? 2'b10 : 2'b01;
        p = alt ? (alt_phase ? 9 : 7) : 8;
        alt_phase = ~alt_phase;
        drive(cur, p);
    endtask

    task automatic send_sync();
        cur = 2'b01;
        ones_run = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            ones_run = b[i] ? ones_run + 1 : 0;
            if (ones_run == 6) begin
                send_bit(1'b0);
                ones_run = 0;
            end
        end
    endtask

    task automatic send_eop();
        drive(2'b00, 16);
        drive(2'b01, 8);
        cur = 2'b01;
        drive(2'b01, 30);
    endtask

    task automatic snap();
        s_sop = n_sop; s_valid = n_valid; s_eop = n_eop;
        s_err = n_err; s_br = n_br; s_cap = cap_n;
    endtask

    task automatic check_pkt(input string tag, input int sop, input int valid, input int eop, input int err);
        check({tag, "_sop"},   n_sop - s_sop, sop);
        check({tag, "_valid"}, n_valid - s_valid, valid);
        check({tag, "_eop"},   n_eop - s_eop, eop);
        check({tag, "_err"},   n_err - s_err, err);
    endtask

    initial begin
        alt = 1'b0;
        alt_phase = 1'b0;
        cur = 2'b01;
        ones_run = 0;
        reset = 1'b1;
        drive(2'b01, 5);
        check("rst_sop", rx_sop, 1'b0);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_eop", rx_eop, 1'b0);
        check("rst_err", rx_err, 1'b0);
        check("rst_active", rx_active, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_bus_reset", bus_reset, 1'b0);
        check("rst_line_state", line_state, 2'b01);
        reset = 1'b0;

        snap();
        drive(2'b01, 200);
        check_pkt("idle", 0, 0, 0, 0);

        // single byte packet
        snap();
        send_sync();
        send_byte(8'h69);
        send_eop();
        check_pkt("pkt69", 1, 1, 1, 0);
        check("pkt69_data", cap[s_cap], 8'h69);
        check("pkt69_active", rx_active, 1'b0);

        // stuffed 0xFF then 0x00
        snap();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_eop();
        check_pkt("stuff", 1, 2, 1, 0);
        check("stuff_d0", cap[s_cap], 8'hFF);
        check("stuff_d1", cap[s_cap + 1], 8'h00);

        // seven ones with no stuff bit
        snap();
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        drive(cur, 20);
        check("noss_err", n_err - s_err, 1);
        check("noss_active", rx_active, 1'b0);
        send_eop();
        check_pkt("noss", 1, 0, 0, 1);

        // jittered bit periods 7/9
        snap();
        alt = 1'b1;
        alt_phase = 1'b0;
        send_sync();
        send_byte(8'h69);
        send_eop();
        alt = 1'b0;
        check_pkt("jit", 1, 1, 1, 0);
        check("jit_data", cap[s_cap], 8'h69);

        // reset mid-byte
        snap();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_active_before", rx_active, 1'b1);
        reset = 1'b1;
        drive(2'b01, 3);
        reset = 1'b0;
        cur = 2'b01;
        drive(2'b01, 60);
        check_pkt("midrst", 1, 0, 0, 0);
        check("midrst_active", rx_active, 1'b0);

        snap();
        send_sync();
        send_byte(8'h69);
        send_eop();
        check_pkt("after_rst", 1, 1, 1, 0);
        check("after_rst_data", cap[s_cap], 8'hA5 ^ 8'hCC);

        // one dribble bit: clean end
        snap();
        send_sync();
        send_byte(8'h69);
        send_bit(1'b0);
        send_eop();
        check_pkt("dribble1", 1, 1, 1, 0);

        // three pending bits: framing error
        snap();
        send_sync();
        send_byte(8'h69);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_eop();
        check_pkt("pend3", 1, 1, 0, 1);

        // bus reset threshold
        snap();
        drive(2'b00, 29);
        drive(2'b01, 40);
        check("br29", n_br - s_br, 0);
        snap();
        drive(2'b00, 30);
        drive(2'b01, 40);
`ifdef USB_RX_BUS_RESET_EN
        check("br30", (n_br - s_br) > 0, 1'b1);
`else
        check("br30_off", n_br - s_br, 0);
`endif
        check("br_no_err", n_err - s_err, 0);

        check("no_clash", n_clash, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
